pipe_hazard_ctrl: RTL and testbench

//  Pipeline sequencer for the IF/ID -> ID/EX -> EX/MEM path. It detects load-use hazards,
//  EX-stage redirects (taken branch or jump) and MEM-stage wait states. It drives the
//  PC/IF-ID enables, the IF/ID flush and the ID/EX NOP-insert strobe.
//  A NOP is alu_op=ADD, alu_src=1, all write/branch/jump controls 0.
//  It also keeps saturating stall/flush event counters for debug.

---
 rtl/pipe_hazard_ctrl.sv | 168 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Hazard sequencer for the IF/ID -> ID/EX -> EX/MEM path of an in-order core.
// It resolves three kinds of hazard:
//   - load-use: a one-cycle bubble is inserted into ID/EX while PC and IF/ID
//     hold their values,
//   - EX-stage redirect (taken branch or jump): IF/ID and ID/EX are flushed
//     for REDIRECT_BUBBLES cycles,
//   - MEM-stage wait state: the whole pipe is frozen until the access is done.
// It also keeps two saturating debug counters: stall cycles and accepted
// redirects.
//
// Ports
//   clk, rst                  clock (rising edge); asynchronous active-high reset
//   id_rs1, id_rs2            source registers of the instruction in ID
//   id_uses_rs1, id_uses_rs2  the ID instruction actually reads that source
//   ex_rd, ex_mem_read        destination register of the EX instruction, and
//                             whether that instruction is a load
//   ex_redirect               EX resolved a taken branch or jump
//   mem_req, mem_ready        MEM access in flight / access completes this cycle
//   pc_en, if_id_en           load enables for PC and IF/ID
//   if_id_flush               IF/ID loads a NOP instead of the fetched word
//   id_ex_nop                 ID/EX captures NOP controls on this edge
//   pipe_hold                 ID/EX, EX/MEM and MEM/WB do not capture
//   state                     00 RUN, 01 MEM_WAIT, 10 FLUSH
//   stall_cnt, flush_cnt      saturating debug counters
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int NUM_REGS         = 32,
  parameter int REG_SEL          = $clog2(NUM_REGS),
  parameter int REDIRECT_BUBBLES = 2,
  parameter int CNT_W            = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [REG_SEL-1:0] id_rs1,
  input  logic [REG_SEL-1:0] id_rs2,
  input  logic               id_uses_rs1,
  input  logic               id_uses_rs2,
  input  logic [REG_SEL-1:0] ex_rd,
  input  logic               ex_mem_read,
  input  logic               ex_redirect,
  input  logic               mem_req,
  input  logic               mem_ready,
  output logic               pc_en,
  output logic               if_id_en,
  output logic               if_id_flush,
  output logic               id_ex_nop,
  output logic               pipe_hold,
  output logic [1:0]         state,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_FLUSH    = 2'b10
  } state_e;

  // The bubble counter only has to hold REDIRECT_BUBBLES-1.
  localparam int BUB_W = (REDIRECT_BUBBLES > 1) ? $clog2(REDIRECT_BUBBLES) : 1;
  localparam logic [BUB_W-1:0] BUB_INIT = BUB_W'(REDIRECT_BUBBLES - 1);
  localparam logic [BUB_W-1:0] BUB_ONE  = BUB_W'(1);

  state_e             state_q, state_d;
  logic [BUB_W-1:0]   bub_q, bub_d;
  logic [CNT_W-1:0]   stall_cnt_q, flush_cnt_q;
  logic               redirect_acc;
  logic               lu;
  logic               mw;

  // x0 is hard-wired to zero, so a load targeting it never creates a hazard.
  assign lu = ex_mem_read && (ex_rd != '0) &&
              ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
               (id_uses_rs2 && (id_rs2 == ex_rd)));
  assign mw = mem_req && !mem_ready;

  // Strobes are combinational so a hazard takes effect in the cycle it is seen.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_nop    = 1'b0;
    pipe_hold    = 1'b0;
    state_d      = state_q;
    bub_d        = bub_q;
    redirect_acc = 1'b0;

    unique case (state_q)
      ST_FLUSH: begin
        if (mw) begin
          // Memory stall wins; the flush simply resumes once MEM is done.
          pc_en     = 1'b0;
          if_id_en  = 1'b0;
          pipe_hold = 1'b1;
        end else begin
          // EX holds a NOP here, so ex_redirect cannot legitimately be set.
          if_id_flush = 1'b1;
          id_ex_nop   = 1'b1;
          bub_d       = bub_q - 1'b1;
          if (bub_q == BUB_ONE) state_d = ST_RUN;
        end
      end
      default: begin
        // RUN and MEM_WAIT share one evaluation: the first cycle after a
        // memory wait acts on any redirect or load-use that was held.
        if (mw) begin
          pc_en     = 1'b0;
          if_id_en  = 1'b0;
          pipe_hold = 1'b1;
          state_d   = ST_MEM_WAIT;
        end else if (ex_redirect) begin
          if_id_flush  = 1'b1;
          id_ex_nop    = 1'b1;
          redirect_acc = 1'b1;
          bub_d        = BUB_INIT;
          state_d      = (REDIRECT_BUBBLES > 1) ? ST_FLUSH : ST_RUN;
        end else if (lu) begin
          // Single bubble: next cycle the load has moved to MEM and lu drops.
          pc_en     = 1'b0;
          if_id_en  = 1'b0;
          id_ex_nop = 1'b1;
          state_d   = ST_RUN;
        end else begin
          state_d = ST_RUN;
        end
      end
    endcase

    // Reset is asynchronous, so the strobes must show reset values at once.
    if (rst) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      if_id_flush = 1'b1;
      id_ex_nop   = 1'b1;
      pipe_hold   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      bub_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading the
      // pre-edge values, independent of statement order.
      state_q <= state_d;
      bub_q   <= bub_d;
      if (!pc_en && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (redirect_acc && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign state     = state_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  // A redirect while flushing means the upstream pipe let a non-NOP into EX.
  a_no_redirect_in_flush : assert property (
    @(posedge clk) disable iff (rst) !((state_q == ST_FLUSH) && ex_redirect)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Self-checking bench for pipe_hazard_ctrl. Each cycle the bench drives the
// inputs, pushes the outputs a reference model predicts onto a scoreboard
// queue, and pops/compares them against the DUT on the falling edge. A second
// instance with CNT_W=2 shares the stimulus to observe counter saturation.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam int RB = 2;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       mr;
    logic       redir;
    logic       mreq;
    logic       mrdy;
  } in_t;

  typedef struct packed {
    logic        pc_en;
    logic        if_id_en;
    logic        if_id_flush;
    logic        id_ex_nop;
    logic        pipe_hold;
    logic [1:0]  state;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
    logic [1:0]  sat_stall;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_uses_rs1, id_uses_rs2, ex_mem_read, ex_redirect, mem_req, mem_ready;
  logic        pc_en, if_id_en, if_id_flush, id_ex_nop, pipe_hold;
  logic [1:0]  state;
  logic [15:0] stall_cnt, flush_cnt;
  logic        s_pc_en, s_if_id_en, s_if_id_flush, s_id_ex_nop, s_pipe_hold;
  logic [1:0]  s_state, s_stall_cnt, s_flush_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  exp_t exp_q[$];

  // Reference model state
  int          m_state;
  int          m_bub;
  int          m_stall;
  int          m_flush;
  int          m_sat;
  int          n_state;
  int          n_bub;
  logic        n_acc;

  pipe_hazard_ctrl #(.NUM_REGS(32), .REDIRECT_BUBBLES(RB), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush), .id_ex_nop(id_ex_nop),
    .pipe_hold(pipe_hold), .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_hazard_ctrl #(.NUM_REGS(32), .REDIRECT_BUBBLES(RB), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(s_pc_en), .if_id_en(s_if_id_en), .if_id_flush(s_if_id_flush),
    .id_ex_nop(s_id_ex_nop), .pipe_hold(s_pipe_hold), .state(s_state),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic in_t idle_in();
    in_t v;
    v = '0;
    return v;
  endfunction

  // Predict this cycle's outputs from the model state and inputs, and compute
  // the model's next state (committed at the rising edge).
  task automatic model_eval(input in_t v, output exp_t e);
    logic lu, mw;
    lu = v.mr && (v.rd != 5'd0) &&
         ((v.u1 && (v.rs1 == v.rd)) || (v.u2 && (v.rs2 == v.rd)));
    mw = v.mreq && !v.mrdy;
    if (v.rst) begin
      m_state = 0; m_bub = 0; m_stall = 0; m_flush = 0; m_sat = 0;
    end
    n_state = m_state;
    n_bub   = m_bub;
    n_acc   = 1'b0;
    e = '0;
    e.pc_en    = 1'b1;
    e.if_id_en = 1'b1;
    if (v.rst) begin
      e.pc_en = 1'b0; e.if_id_en = 1'b0; e.if_id_flush = 1'b1; e.id_ex_nop = 1'b1;
    end else if (mw) begin
      e.pc_en = 1'b0; e.if_id_en = 1'b0; e.pipe_hold = 1'b1;
      n_state = (m_state == 2) ? 2 : 1;
    end else if (m_state == 2) begin
      e.if_id_flush = 1'b1; e.id_ex_nop = 1'b1;
      n_bub   = m_bub - 1;
      n_state = (n_bub == 0) ? 0 : 2;
    end else if (v.redir) begin
      e.if_id_flush = 1'b1; e.id_ex_nop = 1'b1;
      n_acc   = 1'b1;
      n_bub   = RB - 1;
      n_state = (RB > 1) ? 2 : 0;
    end else if (lu) begin
      e.pc_en = 1'b0; e.if_id_en = 1'b0; e.id_ex_nop = 1'b1;
      n_state = 0;
    end else begin
      n_state = 0;
    end
    e.state     = 2'(m_state);
    e.stall_cnt = 16'(m_stall);
    e.flush_cnt = 16'(m_flush);
    e.sat_stall = 2'(m_sat);
  endtask

  // One clock cycle: drive, predict, compare at negedge, commit at posedge.
  task automatic step(input in_t v);
    exp_t e, g;
    rst         = v.rst;
    id_rs1      = v.rs1;
    id_rs2      = v.rs2;
    id_uses_rs1 = v.u1;
    id_uses_rs2 = v.u2;
    ex_rd       = v.rd;
    ex_mem_read = v.mr;
    ex_redirect = v.redir;
    mem_req     = v.mreq;
    mem_ready   = v.mrdy;
    model_eval(v, e);
    exp_q.push_back(e);
    @(negedge clk);
    g = exp_q.pop_front();
    check("pc_en",       32'(pc_en),       32'(g.pc_en));
    check("if_id_en",    32'(if_id_en),    32'(g.if_id_en));
    check("if_id_flush", 32'(if_id_flush), 32'(g.if_id_flush));
    check("id_ex_nop",   32'(id_ex_nop),   32'(g.id_ex_nop));
    check("pipe_hold",   32'(pipe_hold),   32'(g.pipe_hold));
    check("state",       32'(state),       32'(g.state));
    check("stall_cnt",   32'(stall_cnt),   32'(g.stall_cnt));
    check("flush_cnt",   32'(flush_cnt),   32'(g.flush_cnt));
    check("sat_stall",   32'(s_stall_cnt), 32'(g.sat_stall));
    @(posedge clk);
    if (!v.rst) begin
      if (!g.pc_en) begin
        m_stall = m_stall + 1;
        if (m_sat < 3) m_sat = m_sat + 1;
      end
      if (n_acc) m_flush = m_flush + 1;
      m_state = n_state;
      m_bub   = n_bub;
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    in_t v;
    v = idle_in();
    v.rst = 1'b1;
    step(v);
    step(v);
    step(idle_in());
  endtask

  initial begin
    in_t v;
    m_state = 0; m_bub = 0; m_stall = 0; m_flush = 0; m_sat = 0;
    rst = 1'b1;
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_mem_read = 1'b0;
    ex_redirect = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset values, then a few idle cycles
    do_reset();
    step(idle_in());

    // Load-use on rs2 -> one bubble
    v = idle_in();
    v.mr = 1'b1; v.rd = 5'd5; v.rs2 = 5'd5; v.u2 = 1'b1;
    step(v);
    step(idle_in());
    check("lu_stall_total", 32'(stall_cnt), 32'd1);
    // Same pattern on x0 -> no stall
    v.rd = 5'd0; v.rs2 = 5'd0;
    step(v);
    // Matching rs1 that is not read -> no stall
    v = idle_in();
    v.mr = 1'b1; v.rd = 5'd7; v.rs1 = 5'd7; v.u1 = 1'b0;
    step(v);
    // Matching rs1 that is read -> stall
    v.u1 = 1'b1;
    step(v);
    step(idle_in());
    check("lu_stall_after_x0", 32'(stall_cnt), 32'd2);

    // Redirect pulse -> two flush cycles
    do_reset();
    v = idle_in();
    v.redir = 1'b1;
    step(v);
    check("redir_state_flush", 32'(state), 32'd2);
    step(idle_in());
    step(idle_in());
    check("redir_flush_cnt", 32'(flush_cnt), 32'd1);
    check("redir_state_run", 32'(state), 32'd0);

    // Memory wait for three cycles, ready on the fourth
    do_reset();
    v = idle_in();
    v.mreq = 1'b1;
    repeat (3) step(v);
    check("mw_stall_cnt", 32'(stall_cnt), 32'd3);
    v.mrdy = 1'b1;
    step(v);
    check("mw_back_to_run", 32'(state), 32'd0);

    // mw + redirect + load-use together: hold, then take the redirect only
    do_reset();
    v = idle_in();
    v.mreq = 1'b1; v.redir = 1'b1;
    v.mr = 1'b1; v.rd = 5'd9; v.rs1 = 5'd9; v.u1 = 1'b1;
    step(v);
    step(v);
    v.mrdy = 1'b1;
    step(v);
    step(idle_in());
    step(idle_in());
    check("simul_flush_cnt", 32'(flush_cnt), 32'd1);
    check("simul_stall_cnt", 32'(stall_cnt), 32'd2);

    // Reset asserted in the middle of a flush
    v = idle_in();
    v.redir = 1'b1;
    step(v);
    check("pre_rst_flush", 32'(state), 32'd2);
    v = idle_in();
    v.rst = 1'b1;
    step(v);
    check("rst_mid_flush_cnt", 32'(flush_cnt), 32'd0);
    step(idle_in());

    // Five load-use stalls -> 2-bit counter saturates at 3
    do_reset();
    for (int i = 0; i < 5; i++) begin
      v = idle_in();
      v.mr = 1'b1; v.rd = 5'd3; v.rs2 = 5'd3; v.u2 = 1'b1;
      step(v);
      step(idle_in());
    end
    check("sat_stall_cnt", 32'(s_stall_cnt), 32'd3);
    check("wide_stall_cnt", 32'(stall_cnt), 32'd5);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      v = idle_in();
      v.rst   = ($urandom_range(0, 59) == 0);
      v.rs1   = 5'($urandom_range(0, 3));
      v.rs2   = 5'($urandom_range(0, 3));
      v.rd    = 5'($urandom_range(0, 3));
      v.u1    = 1'($urandom_range(0, 1));
      v.u2    = 1'($urandom_range(0, 1));
      v.mr    = 1'($urandom_range(0, 1));
      v.redir = ($urandom_range(0, 5) == 0);
      v.mreq  = ($urandom_range(0, 2) == 0);
      v.mrdy  = 1'($urandom_range(0, 1));
      if (m_state == 2) v.redir = 1'b0;
      step(v);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
